icache_refill: RTL

Refill engine for the 8-line direct-mapped instruction cache. When the cache reports a miss, this block reads the four 16-bit words of the missing 8-byte line from instruction memory through a request/acknowledge handshake. It assembles the words into a 64-bit line and presents the line with its address to the cache's fill inputs. It sits between the cache and instruction memory, and acts as the memory-side source of the cache's line-fill data.

---
 rtl/icache_refill.sv | 105 ++++++++++
 1 files changed

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine.
// On a miss, fetches the four words of the missing 8-byte line from
// instruction memory over a req/ack handshake, then presents the
// assembled 64-bit line and its base address to the cache for one cycle.
module icache_refill #(
    parameter int ADDR_W     = 16,
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_req,
    input  logic [ADDR_W-1:0]            miss_addr,
    output logic                         busy,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [WORD_W-1:0]            mem_rdata,
    output logic                         fill_valid,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [WORD_W*LINE_WORDS-1:0] fill_line
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-4:0]   line_tag;
    logic [1:0]          cnt;
    logic [1:0]          cnt_nxt;
    logic [WORD_W-1:0]   slot [0:LINE_WORDS-1];

    // The byte offset within a line is irrelevant: refills always start at word 0.
    logic unused_offset_bits;
    assign unused_offset_bits = ^miss_addr[2:0];

    // Word counter wraps inside the line so addresses never carry into the tag.
    assign cnt_nxt = cnt + 2'd1;

    // Refill control FSM with registered handshake and fill outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            line_tag   <= '0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_line  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fill_valid <= 1'b0;
                    if (miss_req) begin
                        state    <= READ;
                        line_tag <= miss_addr[ADDR_W-1:3];
                        cnt      <= 2'd0;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= {miss_addr[ADDR_W-1:3], 3'b000};
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        if (cnt == 2'd3) begin
                            state      <= FILL;
                            mem_req    <= 1'b0;
                            fill_valid <= 1'b1;
                            fill_addr  <= {line_tag, 3'b000};
                            fill_line  <= {slot[0], slot[1], slot[2], mem_rdata};
                        end else begin
                            cnt      <= cnt_nxt;
                            mem_addr <= {line_tag, cnt_nxt, 1'b0};
                        end
                    end
                end
                FILL: begin
                    state      <= IDLE;
                    fill_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mem_req    <= 1'b0;
                    fill_valid <= 1'b0;
                end
            endcase
        end
    end

    // Word staging buffer; stale contents are never exposed because
    // fill_line is only loaded after all four words of the current line arrive.
    always_ff @(posedge clk) begin
        if (state == READ && mem_ack) begin
            slot[cnt] <= mem_rdata;
        end
    end

endmodule
